// File: rtl/regread_stage_if.sv
// Pipeline bundle between decode, register-read, execute and writeback,
// plus the generic perf read bus (combinational response, rsp_vld qualifies rsp_dat).
interface regread_stage_if;
  logic        dec_valid;
  logic [31:0] dec_pc, dec_pc_inc, dec_imm32, dec_predicted_pc;
  logic [5:0]  dec_op;
  logic [7:0]  dec_altop;
  logic [3:0]  dec_altaluop;
  logic [3:0]  dec_rd, dec_rs, dec_rt;
  logic        dec_next_is_cont;

  logic        rr_stall;
  logic [31:0] rr_pc, rr_imm32, rr_pc_inc, rr_predicted_pc;
  logic [5:0]  rr_op;
  logic [7:0]  rr_altop;
  logic [3:0]  rr_altaluop;
  logic [3:0]  rr_rd, rr_rs, rr_rt;
  logic        rr_next_is_cont;
  logic [31:0] rr_rs_val, rr_rt_val;

  logic        exec_stall, exec_flush;
  logic [3:0]  exec_of_reg, exec_rd, wb_rd;
  logic [31:0] exec_of_val, exec_rd_val, wb_val;

  modport master (
    output dec_valid, dec_pc, dec_pc_inc, dec_imm32, dec_predicted_pc, dec_op, dec_altop,
           dec_altaluop, dec_rd, dec_rs, dec_rt, dec_next_is_cont,
           exec_stall, exec_flush, exec_of_reg, exec_of_val, exec_rd, exec_rd_val, wb_rd, wb_val,
    input  rr_stall, rr_pc, rr_op, rr_altop, rr_altaluop, rr_rd, rr_rs, rr_rt, rr_imm32,
           rr_pc_inc, rr_next_is_cont, rr_predicted_pc, rr_rs_val, rr_rt_val
  );
  modport slave (
    input  dec_valid, dec_pc, dec_pc_inc, dec_imm32, dec_predicted_pc, dec_op, dec_altop,
           dec_altaluop, dec_rd, dec_rs, dec_rt, dec_next_is_cont,
           exec_stall, exec_flush, exec_of_reg, exec_of_val, exec_rd, exec_rd_val, wb_rd, wb_val,
    output rr_stall, rr_pc, rr_op, rr_altop, rr_altaluop, rr_rd, rr_rs, rr_rt, rr_imm32,
           rr_pc_inc, rr_next_is_cont, rr_predicted_pc, rr_rs_val, rr_rt_val
  );
endinterface

interface perf_if;
  logic        req_vld;
  logic [7:0]  addr;
  logic        rsp_vld;
  logic [63:0] rsp_dat;

  modport master (output req_vld, addr, input rsp_vld, rsp_dat);
  modport slave  (input req_vld, addr, output rsp_vld, rsp_dat);
endinterface

// File: rtl/regread_stage.sv
// Register-read stage: 16x32 register file, operand forwarding, ALU/load hazard bubbles.
// Optional hazard-stall perf counter enabled by defining REGREAD_PERF_EN.
module regread_stage #(
  parameter int          LOAD_LAT  = 2,
  parameter logic [7:0]  PERF_ADDR = 8'h06
) (
  input  logic            i_clk,
  input  logic            i_reset,
  regread_stage_if.slave  pipe,
  perf_if.slave           perf
);

  typedef struct packed {
    logic [5:0]  op;
    logic [7:0]  altop;
    logic [3:0]  altaluop;
    logic [3:0]  rd, rs, rt;
    logic [31:0] pc, imm32, pc_inc, predicted_pc;
    logic        next_is_cont;
    logic [31:0] rs_val, rt_val;
  } rr_t;

  rr_t         rr_q, rr_d;
  logic [31:0] rf_q [16];
  logic [31:0] rf_d [16];
  logic [3:0]  ld_rd_q, ld_rd_d;
  logic [3:0]  ld_cnt_q, ld_cnt_d;
  logic        hazard_alu, hazard_ld, hazard;

  function automatic logic [31:0] operand(
    input logic [3:0] r, input logic [3:0] of_reg, input logic [31:0] of_val,
    input logic [3:0] ex_rd, input logic [31:0] ex_val,
    input logic [3:0] wb_rd, input logic [31:0] wb_val, input logic [31:0] rf_val);
    if (r == 4'd0)          return 32'd0;
    else if (of_reg == r)   return of_val;
    else if (ex_rd == r)    return ex_val;
    else if (wb_rd == r)    return wb_val;
    else                    return rf_val;
  endfunction

  always_comb begin
    hazard_alu = pipe.dec_valid && (rr_q.rd != 4'd0) && !rr_q.op[4] &&
                 ((rr_q.rd == pipe.dec_rs) || (rr_q.rd == pipe.dec_rt));
    // ld_rd is never 0 while ld_cnt is non-zero, so index 0 cannot false-match
    hazard_ld  = pipe.dec_valid && (ld_cnt_q != 4'd0) &&
                 ((ld_rd_q == pipe.dec_rs) || (ld_rd_q == pipe.dec_rt) ||
                  (pipe.dec_op[4] && (ld_rd_q == pipe.dec_rd)));
    hazard     = hazard_alu || hazard_ld;
  end

  assign pipe.rr_stall = !i_reset && !pipe.exec_flush && (pipe.exec_stall || hazard);

  always_comb begin
    rf_d = rf_q;
    if (pipe.wb_rd != 4'd0) rf_d[pipe.wb_rd] = pipe.wb_val;
  end

  always_comb begin
    rr_d     = rr_q;
    ld_rd_d  = ld_rd_q;
    ld_cnt_d = ld_cnt_q;
    if (pipe.exec_flush) begin
      rr_d.op    = 6'd0;
      rr_d.altop = 8'd0;
      rr_d.rd    = 4'd0;
      ld_cnt_d   = 4'd0;
    end else if (!pipe.exec_stall) begin
      ld_cnt_d = (ld_cnt_q != 4'd0) ? ld_cnt_q - 4'd1 : 4'd0;
      if (!pipe.dec_valid || hazard) begin
        rr_d.op    = 6'd0;
        rr_d.altop = 8'd0;
        rr_d.rd    = 4'd0;
      end else begin
        rr_d.op           = pipe.dec_op;
        rr_d.altop        = pipe.dec_altop;
        rr_d.altaluop     = pipe.dec_altaluop;
        rr_d.rd           = pipe.dec_rd;
        rr_d.rs           = pipe.dec_rs;
        rr_d.rt           = pipe.dec_rt;
        rr_d.pc           = pipe.dec_pc;
        rr_d.imm32        = pipe.dec_imm32;
        rr_d.pc_inc       = pipe.dec_pc_inc;
        rr_d.predicted_pc = pipe.dec_predicted_pc;
        rr_d.next_is_cont = pipe.dec_next_is_cont;
        rr_d.rs_val = operand(pipe.dec_rs, pipe.exec_of_reg, pipe.exec_of_val, pipe.exec_rd,
                              pipe.exec_rd_val, pipe.wb_rd, pipe.wb_val, rf_q[pipe.dec_rs]);
        rr_d.rt_val = operand(pipe.dec_rt, pipe.exec_of_reg, pipe.exec_of_val, pipe.exec_rd,
                              pipe.exec_rd_val, pipe.wb_rd, pipe.wb_val, rf_q[pipe.dec_rt]);
        // A fresh load replaces the single scoreboard slot
        if (pipe.dec_op[4] && (pipe.dec_rd != 4'd0)) begin
          ld_rd_d  = pipe.dec_rd;
          ld_cnt_d = 4'(LOAD_LAT);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rr_q     <= '0;
      rf_q     <= '{default: 32'd0};
      ld_rd_q  <= 4'd0;
      ld_cnt_q <= 4'd0;
    end else begin
      rr_q     <= rr_d;
      rf_q     <= rf_d;
      ld_rd_q  <= ld_rd_d;
      ld_cnt_q <= ld_cnt_d;
    end
  end

  assign pipe.rr_op           = rr_q.op;
  assign pipe.rr_altop        = rr_q.altop;
  assign pipe.rr_altaluop     = rr_q.altaluop;
  assign pipe.rr_rd           = rr_q.rd;
  assign pipe.rr_rs           = rr_q.rs;
  assign pipe.rr_rt           = rr_q.rt;
  assign pipe.rr_pc           = rr_q.pc;
  assign pipe.rr_imm32        = rr_q.imm32;
  assign pipe.rr_pc_inc       = rr_q.pc_inc;
  assign pipe.rr_predicted_pc = rr_q.predicted_pc;
  assign pipe.rr_next_is_cont = rr_q.next_is_cont;
  assign pipe.rr_rs_val       = rr_q.rs_val;
  assign pipe.rr_rt_val       = rr_q.rt_val;

`ifdef REGREAD_PERF_EN
  logic [63:0] perf_cnt_q, perf_cnt_d;
  logic        hazard_stall;

  // Only stalls this stage causes itself; execute back-pressure is not counted
  assign hazard_stall = hazard && !pipe.exec_stall && !pipe.exec_flush;

  always_comb perf_cnt_d = perf_cnt_q + {63'd0, hazard_stall};

  always_ff @(posedge i_clk) begin
    if (i_reset) perf_cnt_q <= 64'd0;
    else         perf_cnt_q <= perf_cnt_d;
  end

  assign perf.rsp_vld = perf.req_vld && (perf.addr == PERF_ADDR);
  assign perf.rsp_dat = perf.rsp_vld ? perf_cnt_q : 64'd0;
`else
  logic unused_perf;
  assign unused_perf  = ^{perf.req_vld, perf.addr, PERF_ADDR};
  assign perf.rsp_vld = 1'b0;
  assign perf.rsp_dat = 64'd0;
`endif

endmodule

// File: tb/tb_regread_stage.sv
// Directed, table-driven bench for regread_stage: forwarding priority, hazards,
// load scoreboard, flush, exec_stall hold and the perf bus response.
module tb_regread_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regread_stage_if pif();
  perf_if          pbus();

  regread_stage dut (.i_clk(clk), .i_reset(rst), .pipe(pif), .perf(pbus));

  localparam logic [5:0] ADD = 6'h01, ADDI = 6'h02, LW = 6'h10;

  typedef struct {
    logic        vld;
    logic [5:0]  op;
    logic [3:0]  rd, rs, rt;
    logic [31:0] imm;
    logic [3:0]  of_reg;
    logic [31:0] of_val;
    logic [3:0]  ex_rd;
    logic [31:0] ex_val;
    logic [3:0]  wb_rd;
    logic [31:0] wb_val;
    logic        flush;
    logic        e_stall;
    logic        e_issue;
    logic [31:0] e_rs, e_rt;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t mk(
    input logic vld, input logic [5:0] op, input logic [3:0] rd, input logic [3:0] rs,
    input logic [3:0] rt, input logic [31:0] imm, input logic [3:0] of_reg,
    input logic [31:0] of_val, input logic [3:0] ex_rd, input logic [31:0] ex_val,
    input logic [3:0] wb_rd, input logic [31:0] wb_val, input logic flush,
    input logic e_stall, input logic e_issue, input logic [31:0] e_rs, input logic [31:0] e_rt);
    vec_t v;
    v.vld = vld; v.op = op; v.rd = rd; v.rs = rs; v.rt = rt; v.imm = imm;
    v.of_reg = of_reg; v.of_val = of_val; v.ex_rd = ex_rd; v.ex_val = ex_val;
    v.wb_rd = wb_rd; v.wb_val = wb_val; v.flush = flush;
    v.e_stall = e_stall; v.e_issue = e_issue; v.e_rs = e_rs; v.e_rt = e_rt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v, input int idx);
    pif.dec_valid        = v.vld;
    pif.dec_op           = v.op;
    pif.dec_altop        = 8'h40 + 8'(idx);
    pif.dec_altaluop     = 4'(idx);
    pif.dec_rd           = v.rd;
    pif.dec_rs           = v.rs;
    pif.dec_rt           = v.rt;
    pif.dec_imm32        = v.imm;
    pif.dec_pc           = 32'h1000 + 32'(idx * 4);
    pif.dec_pc_inc       = 32'h1004 + 32'(idx * 4);
    pif.dec_predicted_pc = 32'h1008 + 32'(idx * 4);
    pif.dec_next_is_cont = idx[0];
    pif.exec_of_reg      = v.of_reg;
    pif.exec_of_val      = v.of_val;
    pif.exec_rd          = v.ex_rd;
    pif.exec_rd_val      = v.ex_val;
    pif.wb_rd            = v.wb_rd;
    pif.wb_val           = v.wb_val;
    pif.exec_flush       = v.flush;
    pif.exec_stall       = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    drive(v, idx);
    #1;
    chk($sformatf("v%0d.stall", idx), 64'(pif.rr_stall), 64'(v.e_stall));
    @(posedge clk); #1;
    if (v.e_issue) begin
      chk($sformatf("v%0d.op", idx), 64'(pif.rr_op), 64'(v.op));
      chk($sformatf("v%0d.rd", idx), 64'(pif.rr_rd), 64'(v.rd));
      chk($sformatf("v%0d.altop", idx), 64'(pif.rr_altop), 64'(8'h40 + 8'(idx)));
      chk($sformatf("v%0d.rs_val", idx), 64'(pif.rr_rs_val), 64'(v.e_rs));
      chk($sformatf("v%0d.rt_val", idx), 64'(pif.rr_rt_val), 64'(v.e_rt));
      chk($sformatf("v%0d.imm", idx), 64'(pif.rr_imm32), 64'(v.imm));
      chk($sformatf("v%0d.pc", idx), 64'(pif.rr_pc), 64'(32'h1000 + 32'(idx * 4)));
      chk($sformatf("v%0d.pcs", idx),
          {pif.rr_pc_inc, pif.rr_predicted_pc},
          {32'h1004 + 32'(idx * 4), 32'h1008 + 32'(idx * 4)});
      chk($sformatf("v%0d.misc", idx), 64'({pif.rr_altaluop, pif.rr_next_is_cont}),
          64'({4'(idx), idx[0]}));
    end else begin
      chk($sformatf("v%0d.bubble", idx),
          64'({pif.rr_op, pif.rr_altop, pif.rr_rd}), 64'd0);
    end
  endtask

  initial begin
    vec_t v;
    pbus.req_vld = 1'b0;
    pbus.addr    = 8'h00;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset.bundle", 64'({pif.rr_op, pif.rr_altop, pif.rr_rd, pif.rr_rs, pif.rr_rt}), 64'd0);
    chk("reset.pc_imm", {pif.rr_pc, pif.rr_imm32}, 64'd0);
    chk("reset.vals", {pif.rr_rs_val, pif.rr_rt_val}, 64'd0);
    chk("reset.stall", 64'(pif.rr_stall), 64'd0);

    //            vld op   rd  rs  rt  imm        ofr ofv         exr exv         wbr wbv           fl st is rs_val        rt_val
    vecs.push_back(mk(1, ADDI, 1,  0,  0,  32'd5,     0, 32'h0,      0, 32'h0,      0, 32'h0,        0, 0, 1, 32'h0,        32'h0));
    vecs.push_back(mk(1, ADD,  2,  0,  0,  32'd0,     0, 32'h0,      0, 32'h0,      0, 32'h0,        0, 0, 1, 32'h0,        32'h0));
    vecs.push_back(mk(1, ADD,  3,  2,  1,  32'd0,     0, 32'h0,      0, 32'h0,      0, 32'h0,        0, 1, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, ADD,  3,  2,  1,  32'd0,     2, 32'h1234,   1, 32'd5,      0, 32'h0,        0, 0, 1, 32'h1234,     32'd5));
    vecs.push_back(mk(1, ADD,  6,  7,  0,  32'd0,     7, 32'hAAAA,   7, 32'hBBBB,   7, 32'hCCCC,     0, 0, 1, 32'hAAAA,     32'h0));
    vecs.push_back(mk(1, ADD,  8,  7,  7,  32'd0,     0, 32'h0,      7, 32'h1111,   0, 32'h0,        0, 0, 1, 32'h1111,     32'h1111));
    vecs.push_back(mk(1, ADD,  9,  7,  6,  32'd0,     0, 32'h0,      0, 32'h0,      7, 32'h2222,     0, 0, 1, 32'h2222,     32'h0));
    vecs.push_back(mk(1, ADD,  10, 7,  0,  32'd0,     0, 32'h0,      0, 32'h0,      0, 32'h0,        0, 0, 1, 32'h2222,     32'h0));
    vecs.push_back(mk(1, LW,   4,  0,  0,  32'd8,     0, 32'h0,      0, 32'h0,      0, 32'h0,        0, 0, 1, 32'h0,        32'h0));
    vecs.push_back(mk(1, ADD,  11, 4,  0,  32'd0,     0, 32'h0,      0, 32'h0,      0, 32'h0,        0, 1, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, ADD,  11, 4,  0,  32'd0,     0, 32'h0,      0, 32'h0,      0, 32'h0,        0, 1, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, ADD,  11, 4,  0,  32'd0,     0, 32'h0,      0, 32'h0,      4, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF, 32'h0));
    vecs.push_back(mk(0, ADD,  12, 0,  0,  32'd0,     0, 32'h0,      0, 32'h0,      0, 32'h0,        0, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, LW,   5,  0,  0,  32'd0,     0, 32'h0,      0, 32'h0,      0, 32'h0,        0, 0, 1, 32'h0,        32'h0));
    vecs.push_back(mk(1, LW,   5,  0,  0,  32'd0,     0, 32'h0,      0, 32'h0,      0, 32'h0,        0, 1, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, LW,   5,  0,  0,  32'd0,     0, 32'h0,      0, 32'h0,      0, 32'h0,        1, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, LW,   5,  0,  0,  32'd4,     0, 32'h0,      0, 32'h0,      0, 32'h0,        0, 0, 1, 32'h0,        32'h0));
    vecs.push_back(mk(1, ADD,  12, 1,  2,  32'd0,     0, 32'h0,      0, 32'h0,      0, 32'h0,        0, 0, 1, 32'h0,        32'h0));
    vecs.push_back(mk(0, ADD,  0,  0,  0,  32'd0,     0, 32'h0,      0, 32'h0,      0, 32'h0,        0, 0, 0, 32'h0,        32'h0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // exec_stall hold: bundle for idx 100 must survive three stalled cycles
    apply(mk(1, ADD, 13, 0, 0, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0), 100);
    for (int k = 0; k < 3; k++) begin
      v = mk(1, ADD, 14, 0, 0, 32'h99, 0, 0, 0, 0, (k < 2) ? 4'd5 : 4'd0,
             (k < 2) ? 32'h55AA55AA : 32'hFFFFFFFF, 0, 1, 0, 0, 0);
      drive(v, 101);
      pif.exec_stall = 1'b1;
      #1;
      chk($sformatf("hold%0d.stall", k), 64'(pif.rr_stall), 64'd1);
      @(posedge clk); #1;
      chk($sformatf("hold%0d.rd_op", k), 64'({pif.rr_rd, pif.rr_op}), 64'({4'd13, ADD}));
      chk($sformatf("hold%0d.pc_imm", k), {pif.rr_pc, pif.rr_imm32},
          {32'h1000 + 32'd400, 32'h77});
    end
    apply(mk(1, ADD, 14, 5, 0, 32'h99, 0, 32'hBAD, 0, 0, 0, 0, 0, 0, 1, 32'h55AA55AA, 32'h0), 102);

    pbus.req_vld = 1'b1;
    pbus.addr    = 8'h06;
    #1;
`ifdef REGREAD_PERF_EN
    chk("perf.vld", 64'(pbus.rsp_vld), 64'd1);
    chk("perf.count", pbus.rsp_dat, 64'd4);
`else
    chk("perf.vld", 64'(pbus.rsp_vld), 64'd0);
    chk("perf.idle_dat", pbus.rsp_dat, 64'd0);
`endif
    pbus.req_vld = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/regread_stage.md
Name: regread_stage

Overview:
- Register-read stage between decode and the 2-cycle execute stage.
- Holds the 16x32 architectural register file and resolves rs/rt operands, forwarding from execute and writeback.
- Detects hazards the forwarding network cannot cover and inserts bubbles.
- Drives the registered rr_* bundle consumed by execute.

Parameters:
- LOAD_LAT, 2, cycles after a load leaves rr_* before wb_rd/wb_val carry its result.
- PERF_ADDR, 8'h06, perf_if address of the hazard-stall counter.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- dec_valid  in  1  decode bundle valid
- dec_pc, dec_pc_inc, dec_imm32, dec_predicted_pc  in  32 each  passed to rr_*
- dec_op  in  6  opcode; loads have op[4]=1
- dec_altop  in  8  alternate opcode
- dec_altaluop  in  4  ALU sub-op
- dec_rd, dec_rs, dec_rt  in  4 each  register indices
- dec_next_is_cont  in  1  passed through
- rr_stall  out  1  decode must hold its bundle
- rr_pc, rr_op, rr_altop, rr_altaluop, rr_rd, rr_rs, rr_rt, rr_imm32, rr_pc_inc, rr_next_is_cont, rr_predicted_pc  out  widths as the dec_* sources  registered bundle to execute
- rr_rs_val, rr_rt_val  out  32 each  resolved operands
- exec_stall, exec_flush  in  1 each  from execute
- exec_of_reg / exec_of_val  in  4/32  execute stage-2 result, combinational
- exec_rd / exec_rd_val  in  4/32  execute registered result
- wb_rd / wb_val  in  4/32  register-file write port; rd 0 means no write
- perf  perf_if  performance bus

Behaviour:
- Reset: all rr_* outputs and every register-file entry clear to 0. Load scoreboard clears. rr_stall=0.
- Latency: 1 cycle, dec_* to rr_*.
- Register 0 reads as 0. A write to register 0 is ignored.
- Operand priority for index r≠0, per operand:
  - exec_of_reg==r → exec_of_val
  - else exec_rd==r → exec_rd_val
  - else wb_rd==r → wb_val (same-cycle write bypass)
  - else register file.
- Register-file write: at posedge when wb_rd≠0. Also occurs during stall and flush, but not during reset.
- ALU hazard: rr_rd≠0, rr_op[4]=0, dec_valid, and rr_rd matches dec_rs or dec_rt. Execute has no result yet, so:
  - rr_stall=1
  - a bubble is issued (rr_op=0, rr_altop=0, rr_rd=0)
  - the dec bundle is held upstream
  - cost is exactly 1 cycle.
- Load scoreboard: single slot {ld_rd, ld_cnt}.
  - Load issue: when a load with rd≠0 is issued, ld_rd←rd and ld_cnt←LOAD_LAT.
  - Count-down: ld_cnt decrements every non-stalled cycle and saturates at 0.
  - Load hazard: ld_cnt≠0 and dec_rs or dec_rt equals ld_rd. Gives rr_stall=1 and a bubble.
  - Issue vs. pending hazard: a new load cannot issue while ld_cnt≠0 and its own rd==ld_rd; this is treated as a hazard.
- exec_flush: highest priority after reset.
  - rr_* becomes a bubble.
  - rr_stall=0.
  - ld_cnt←0.
  - dec_* is discarded.
- exec_stall (without flush): every rr_* register holds and rr_stall=1. The scoreboard and hazard logic freeze.
- dec_valid=0: issue a bubble; no stall.
- Bubble encoding: op=0, altop=0, rd=0. Other fields may hold stale values.
- Priority for simultaneous events: reset > exec_flush > exec_stall > hazard > issue.

Optional Feature:
- Macro: REGREAD_PERF_EN.
- Defined: a 64-bit counter instance at PERF_ADDR counts cycles in which rr_stall=1 due to a hazard (exec_stall excluded). It is readable via perf and clears on reset.
- Undefined: no counter; perf drives the perf_if idle/zero response.

Test Plan:
- Reset, then issue ADDI r1 with imm 5 and rs=r0 → next cycle rr_rs_val=0, rr_imm32=5, rr_rd=1. All registers read 0.
- ALU then dependent ALU: ADD r2 followed by ADD r3 using rs=r2 → one bubble, rr_stall high exactly 1 cycle. Second ADD captures rr_rs_val=exec_of_val (e.g. 0x1234).
- Load followed by use, LOAD_LAT=2: LW r4 then ADD using r4 → stall 2 cycles. The operand is taken from wb_val=0xDEADBEEF in the same-cycle bypass.
- Flush during a load hazard: exec_flush=1 while ld_cnt=1 → rr_op=0, rr_rd=0, rr_stall=0 on the following cycle. The next decode bundle issues without a stall.
- exec_stall held for 3 cycles with wb_rd=5 writes → rr_* unchanged across the stall. A later read of r5 returns the written value; a write to r0 leaves r0 reading 0.
- REGREAD_PERF_EN: 3 hazard stalls and 2 exec_stall cycles → counter reads 3.
